// File: rtl/pad_cond_pkg.sv
// Shared types and helpers for the pad input conditioner.
// Build-time default channel count when the pad-ring headers have not supplied one.
`ifndef NUM_INPUT_PADS
`define NUM_INPUT_PADS 4
`endif

package pad_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } chan_state_t;

  // Debounce counter only has to reach ticks-1; keep at least one bit.
  function automatic int cnt_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/pad_debounce_chan.sv
// One conditioned pad channel: 2-flop synchronizer, debounce FSM,
// rise/fall pulse generation and a sticky write-1-to-clear event flag.
module pad_debounce_chan
  import pad_cond_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  input  logic enable,
  input  logic tick,
  input  logic event_clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic event_pending
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q, sync_d;
  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          ev_q, ev_d;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], pad_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // A pulse in flight beats a simultaneous clear.
    ev_d    = rise_q | fall_q | (ev_q & ~event_clr);

    if (!enable) begin
      if (state_q == CHK_HI) state_d = STABLE_LO;
      if (state_q == CHK_LO) state_d = STABLE_HI;
      cnt_d = '0;
    end else begin
      case (state_q)
        STABLE_LO: if (s) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
        CHK_HI: if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE_HI: if (!s) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
        CHK_LO: if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ev_q    <= ev_d;
    end
  end

  assign level         = level_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign event_pending = ev_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner top: reset synchronizer, shared debounce prescaler
// and an array of per-channel debounce engines.
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int NUM_INPUTS     = `NUM_INPUT_PADS,
  parameter int PRESCALE       = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] pad_in,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] event_clr,
  output logic                  rst_sync_n,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall,
  output logic [NUM_INPUTS-1:0] event_pending
);

  localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [1:0]    rst_q, rst_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb rst_d = {rst_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= rst_d;
  end

  assign rst_sync_n = rst_q[1];

  always_comb begin
    presc_d = presc_q;
    if (!enable)                presc_d = '0;
    else if (presc_q == PRE_LAST) presc_d = '0;
    else                        presc_d = presc_q + PW'(1);
  end

  // Internal state uses the synchronized reset so its release is clean.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) presc_q <= '0;
    else             presc_q <= presc_d;
  end

  assign tick = enable && (presc_q == PRE_LAST);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    pad_debounce_chan #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_sync_n),
      .pad_in       (pad_in[i]),
      .enable       (enable),
      .tick         (tick),
      .event_clr    (event_clr[i]),
      .level        (level[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .event_pending(event_pending[i])
    );
  end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench for pad_input_conditioner (PRESCALE=4, DEBOUNCE_TICKS=3, 4 channels).
module tb_pad_input_conditioner;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pad_in;
  logic         enable;
  logic [N-1:0] event_clr;
  logic         rst_sync_n;
  logic [N-1:0] level, rise, fall, event_pending;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int chan;
    bit is_rise;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];

  pad_input_conditioner #(
    .NUM_INPUTS(N),
    .PRESCALE(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_in       (pad_in),
    .enable       (enable),
    .event_clr    (event_clr),
    .rst_sync_n   (rst_sync_n),
    .level        (level),
    .rise         (rise),
    .fall         (fall),
    .event_pending(event_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int chan, input bit is_rise, input int lo, input int hi);
    exp_t e;
    e.chan = chan; e.is_rise = is_rise; e.lo = cyc + lo; e.hi = cyc + hi;
    exp_q.push_back(e);
  endtask

  // Monitor: pulses are matched against the scoreboard; width and flag follow-up checked too.
  initial begin
    logic [N-1:0] prev_r, prev_f, ev_chk;
    prev_r = '0; prev_f = '0; ev_chk = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ev_chk[i] && rst_n) chk($sformatf("ev_after_pulse[%0d]", i), 32'(event_pending[i]), 32'd1);
        if (prev_r[i]) chk($sformatf("rise_width[%0d]", i), 32'(rise[i]), 32'd0);
        if (prev_f[i]) chk($sformatf("fall_width[%0d]", i), 32'(fall[i]), 32'd0);
        if (rise[i] || fall[i]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].chan == i && exp_q[k].is_rise == rise[i] && !(rise[i] && fall[i])) idx = k;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_pulse[%0d]: rise %0b fall %0b at cycle %0d, none expected", i, rise[i], fall[i], cyc);
          end else begin
            if (cyc < exp_q[idx].lo || cyc > exp_q[idx].hi) begin
              checks++; errors++;
              $display("FAIL pulse_latency[%0d]: cycle %0d expected %0d..%0d", i, cyc, exp_q[idx].lo, exp_q[idx].hi);
            end else checks++;
            chk($sformatf("level_at_pulse[%0d]", i), 32'(level[i]), 32'(exp_q[idx].is_rise));
            exp_q.delete(idx);
          end
        end
      end
      prev_r = rise; prev_f = fall; ev_chk = rise | fall;
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0; pad_in = '0; enable = 1'b1; event_clr = '0;

    // Reset state and synchronizer release
    #1;
    chk("rst_sync_n_in_reset", 32'(rst_sync_n), 32'd0);
    chk("outputs_in_reset", {level, rise, fall, event_pending}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sync_n_after_1_edge", 32'(rst_sync_n), 32'd0);
    @(negedge clk);
    chk("rst_sync_n_after_2_edges", 32'(rst_sync_n), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("rst_sync_n_async_assert", 32'(rst_sync_n), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cycles(6);

    // Clean step on channel 0
    pad_in[0] = 1'b1;
    expect_pulse(0, 1'b1, 12, 16);
    cycles(20);
    chk("clean_step_level", 32'(level), 32'h1);
    chk("clean_step_event", 32'(event_pending), 32'h1);

    // Short excursion on channel 1 is rejected
    pad_in[1] = 1'b1;
    cycles(5);
    pad_in[1] = 1'b0;
    cycles(20);
    chk("glitch_level", 32'(level[1]), 32'd0);
    chk("glitch_event", 32'(event_pending[1]), 32'd0);

    // Clear in the same cycle as the rise loses to the set
    pad_in[2] = 1'b1;
    expect_pulse(2, 1'b1, 12, 16);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (rise[2]) seen = 1'b1;
    end
    chk("race_rise_seen", 32'(seen), 32'd1);
    event_clr[2] = 1'b1;
    @(negedge clk); event_clr[2] = 1'b0;
    chk("race_set_wins", 32'(event_pending[2]), 32'd1);
    cycles(3);
    event_clr[2] = 1'b1;
    @(negedge clk); event_clr[2] = 1'b0;
    chk("clear_alone", 32'(event_pending[2]), 32'd0);

    // Disable while channel 3 is checking
    pad_in[3] = 1'b1;
    cycles(6);
    enable = 1'b0;
    cycles(2);
    chk("presc_held_0", 32'(dut.presc_q), 32'd0);
    cycles(20);
    chk("disabled_level3", 32'(level[3]), 32'd0);
    chk("presc_still_0", 32'(dut.presc_q), 32'd0);
    enable = 1'b1;
    expect_pulse(3, 1'b1, 12, 16);
    cycles(20);
    chk("reenable_level3", 32'(level[3]), 32'd1);

    // Move to level 1010, then reset mid-operation
    pad_in[0] = 1'b0; pad_in[2] = 1'b0; pad_in[1] = 1'b1;
    expect_pulse(0, 1'b0, 12, 16);
    expect_pulse(1, 1'b1, 12, 16);
    expect_pulse(2, 1'b0, 12, 16);
    cycles(20);
    chk("pre_reset_level", 32'(level), 32'hA);
    chk("pre_reset_events", 32'(event_pending), 32'hF);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {level, rise, fall, event_pending}, 32'd0);
    chk("mid_reset_rst_sync_n", 32'(rst_sync_n), 32'd0);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;
    expect_pulse(1, 1'b1, 14, 18);
    expect_pulse(3, 1'b1, 14, 18);
    cycles(25);
    chk("post_reset_level", 32'(level), 32'hA);
    chk("post_reset_events", 32'(event_pending), 32'hA);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_input_conditioner.md
# pad_input_conditioner

Conditions the raw input-pad signals (`input_PAD2CORE` from the pad ring) before they reach core logic. Each channel gets a 2-flop synchronizer, a prescaled debounce state machine, one-cycle rise/fall pulses, and sticky event flags. The block also provides a synchronized core reset. It sits directly downstream of the pad ring and upstream of `chip_core`.

## Interface
Parameters:
- `NUM_INPUTS`, default `` `NUM_INPUT_PADS ``: number of conditioned channels, ≥1.
- `PRESCALE`, default 16: clock cycles per debounce sample tick, ≥1.
- `DEBOUNCE_TICKS`, default 4: consecutive stable ticks required to accept a new level, ≥1.

Ports:
- `clk`  in  1: core clock. One clock domain only.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pad_in`  in  NUM_INPUTS: raw pad outputs, asynchronous to `clk`.
- `enable`  in  1: debounce engine enable.
- `event_clr`  in  NUM_INPUTS: write-1-to-clear for `event_pending`.
- `rst_sync_n`  out  1: reset for the core. Asserts asynchronously, deasserts synchronously.
- `level`  out  NUM_INPUTS: debounced level.
- `rise`  out  NUM_INPUTS: one-cycle pulse when `level` goes 0→1.
- `fall`  out  NUM_INPUTS: one-cycle pulse when `level` goes 1→0.
- `event_pending`  out  NUM_INPUTS: sticky flag, set by `rise` or `fall`.

## Operation
- **Reset synchronizer.** Two flops, both async-cleared by `rst_n`, with D=1.
  - `rst_sync_n` goes 0 immediately when `rst_n` falls.
  - `rst_sync_n` goes 1 on the 2nd `clk` rising edge after `rst_n` rises.
- **Synchronizer.** Two flops per channel. Only the output `s[i]` is used downstream.
- **Prescaler.** Counter runs 0..PRESCALE-1 and wraps.
  - `tick` = (count == PRESCALE-1) && enable.
  - While `enable`=0 the counter is held at 0.
  - PRESCALE=1 gives a tick every enabled cycle.
- **Channel FSM** (encoding in package). States: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. Reset state is STABLE_LO.
  - STABLE_LO: if `s`=1 and `enable`, go to CHK_HI with cnt=0.
  - CHK_HI:
    - If `s`=0, go to STABLE_LO with no event.
    - Otherwise, on `tick`, cnt++.
    - When `tick` && cnt==DEBOUNCE_TICKS-1, go to STABLE_HI, set `level`=1 and pulse `rise`.
  - STABLE_HI and CHK_LO are symmetric: `fall` is pulsed and `level` is cleared.
  - While `enable`=0, CHK states return to their STABLE state and cnt=0. `level` is held.
- **Event flags.**
  - `event_pending[i]` sets on `rise[i]|fall[i]`.
  - It clears on `event_clr[i]`.
  - If set and clear occur in the same cycle, set wins.
- **Counter width.** cnt width is $clog2(DEBOUNCE_TICKS) with a minimum of 1. It never exceeds DEBOUNCE_TICKS-1.

## Timing
- **Reset values.** `level`, `rise`, `fall`, `event_pending`, `rst_sync_n`, the sync flops and the prescaler are all 0. All FSMs are in STABLE_LO.
- **Step latency** from a clean pad step to the `level` change: min 2+1+PRESCALE·(DEBOUNCE_TICKS-1)+1, max 2+1+PRESCALE·DEBOUNCE_TICKS+1 cycles.
- **Pulse alignment.** `rise`/`fall` assert in the same cycle `level` changes and last exactly 1 cycle.
- **Flag latency.** `event_pending` rises 1 cycle after the pulse.
- **Glitch rejection.** Any excursion shorter than PRESCALE·(DEBOUNCE_TICKS-1) cycles is rejected: no `level` change, no pulse.
- **Reset mid-check.** `rst_n` asserted during CHK returns the channel to STABLE_LO with `level`=0 and no pulse.
- **Independence.** Channels are independent. Simultaneous pulses on several channels are allowed.

## Structure
- Package `pad_cond_pkg`: `chan_state_t` enum (2-bit) and a `cnt_width()` function.
- Sub-module `pad_debounce_chan`: synchronizer, FSM, counter and event flag for one channel. It is instantiated NUM_INPUTS times in a generate loop.
- The prescaler and reset synchronizer live in the top level. The prescaler is shared by all channels.

## Test plan
All scenarios use PRESCALE=4, DEBOUNCE_TICKS=3, NUM_INPUTS=4.
- **Reset.** Release `rst_n` → `rst_sync_n`=1 after exactly 2 rising edges. Reassert `rst_n` mid-cycle → `rst_sync_n`=0 with no clock edge needed.
- **Clean step.** `pad_in[0]` 0→1 and held → `level[0]`=1 within 12..16 cycles. `rise[0]` is high for exactly 1 cycle and `event_pending[0]`=1 the next cycle. Other channels stay at 0.
- **Glitch.** `pad_in[1]` high for 5 cycles, then low → `level[1]` stays 0, no `rise`/`fall`, `event_pending[1]` stays 0.
- **Event clear race.** `event_clr[2]` pulsed in the same cycle as `rise[2]` → `event_pending[2]`=1. A later `event_clr[2]` alone → 0.
- **Disable.** Deassert `enable` while channel 3 is in CHK_HI → no `rise[3]`, `level[3]`=0, and the prescaler is held at 0. Re-enable with the input still high → `rise[3]` after the normal latency.
- **Reset mid-operation.** Assert `rst_n` with `level`=4'b1010 and flags set → all outputs 0 immediately. After release, the same high inputs produce fresh `rise` pulses.
